fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of write requesters, 2..8.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8: FIFO word width.
REQ-003 The block SHALL have parameter MAX_BURST, default 4: maximum writes per grant, 1..16.
REQ-004 The block SHALL have port wr_clk, input, 1 bit: the single clock (FIFO write-side clock).
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have port req, input, NUM_REQ bits: per-requester "word pending" request.
REQ-007 The block SHALL have port req_data, input, NUM_REQ*DATA_WIDTH bits: requester i word on bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 The block SHALL have port ack, output, NUM_REQ bits: one-hot; ack[i]=1 means requester i's word is written this cycle.
REQ-009 The block SHALL have port full, input, 1 bit: FIFO full flag.
REQ-010 The block SHALL have port almost_full, input, 1 bit: FIFO almost-full flag.
REQ-011 The block SHALL have port wr_enbl, output, 1 bit: FIFO write enable.
REQ-012 The block SHALL have port wr_data, output, DATA_WIDTH bits: FIFO write data.
REQ-013 The block SHALL have port owner_vld, output, 1 bit: a burst owner is locked.
REQ-014 The block SHALL have port owner_id, output, clog2(NUM_REQ) bits: index of the locked owner.

Function
REQ-015 wr_enbl, wr_data and ack SHALL be combinational from state and inputs: zero-latency write in the cycle of the grant.
REQ-016 wr_enbl SHALL equal OR of ack; wr_data SHALL be the acked requester's word, else 0.
REQ-017 No write SHALL be issued while full=1, in any state.
REQ-018 FSM states SHALL be IDLE and BURST; owner_vld=1 only in BURST.
REQ-019 In IDLE the block SHALL select the first asserted req scanning from rr_ptr upward with wrap at NUM_REQ-1 to 0.
REQ-020 In IDLE with winner w and full=0, the block SHALL write w's word and set burst_cnt=1.
REQ-021 After that IDLE write, the block SHALL enter BURST with owner=w if MAX_BURST>1 and almost_full=0; otherwise it SHALL stay IDLE with rr_ptr=(w+1) mod NUM_REQ.
REQ-022 In IDLE with full=1 or no req, the block SHALL stay IDLE, write nothing and leave rr_ptr unchanged.
REQ-023 In BURST with req[owner]=1 and full=0, the block SHALL write owner's word and increment burst_cnt.
REQ-024 In BURST, release to IDLE with rr_ptr=(owner+1) mod NUM_REQ SHALL occur when the write makes burst_cnt=MAX_BURST, or a write occurs with almost_full=1.
REQ-025 In BURST, req[owner]=0 SHALL cause release to IDLE with the same rr_ptr update and no write that cycle.
REQ-026 In BURST with req[owner]=1 and full=1, the block SHALL stay in BURST with no write and burst_cnt held; other requesters SHALL not be granted.
REQ-027 A requester SHALL hold req and req_data stable until acked; the block SHALL not check this.

Reset
REQ-028 With rst=1 at a wr_clk edge: state=IDLE, rr_ptr=0, burst_cnt=0, owner_id=0.
REQ-029 While rst=1, ack, wr_enbl, wr_data and owner_vld SHALL be 0, including mid-burst; no write SHALL be issued.

Configuration
REQ-030 Macro FIFO_ARB_BURST_EN SHALL control bursting.
REQ-031 With FIFO_ARB_BURST_EN defined, behaviour SHALL be as in REQ-018..REQ-026.
REQ-032 Without FIFO_ARB_BURST_EN, MAX_BURST SHALL be ignored, BURST never entered, owner_vld and owner_id tied 0, and every grant a single write followed by rr_ptr advance.

Verification
REQ-033 The bench SHALL cover single requester: req=0001, full=0 -> burst of 4 writes of req_data[7:0], then one IDLE cycle with re-grant to 0, rr_ptr=1.
REQ-034 The bench SHALL cover fairness: req=1111 held, burst on -> ack order 0x4,1x4,2x4,3x4; without macro -> 0,1,2,3,0 one write each.
REQ-035 The bench SHALL cover full stall: owner 2 mid-burst (burst_cnt=2), full=1 for 5 cycles -> wr_enbl=0 and owner_id=2 held; after full=0 -> 2 more writes, then release.
REQ-036 The bench SHALL cover almost_full: almost_full=1, req=0011 -> every grant single write, alternating 0,1; owner_vld stays 0.
REQ-037 The bench SHALL cover early drop: owner 1 deasserts req after 1 write -> IDLE next cycle, rr_ptr=2, no spurious write.
REQ-038 The bench SHALL cover reset mid-burst: rst=1 for 1 cycle during owner 3 burst -> outputs 0 that cycle; after reset, req=1111 -> requester 0 granted first.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// ============================================================================
// Module   : fifo_wr_arbiter_if
// Purpose  : Requester / FIFO write-side bundle for fifo_wr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_wr_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            ack;
   logic                          full;
   logic                          almost_full;
   logic                          wr_enbl;
   logic [DATA_WIDTH-1:0]         wr_data;
   logic                          owner_vld;
   logic [ID_W-1:0]               owner_id;

   // The arbiter side
   modport master (
      input  req, req_data, full, almost_full,
      output ack, wr_enbl, wr_data, owner_vld, owner_id
   );

   // Requesters plus FIFO side
   modport slave (
      output req, req_data, full, almost_full,
      input  ack, wr_enbl, wr_data, owner_vld, owner_id
   );
endinterface

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin FIFO write arbiter with optional burst ownership,
//            enabled by macro FIFO_ARB_BURST_EN (default: single-write grants).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic               wr_clk,
   input  logic               rst,
   fifo_wr_arbiter_if.master  bus
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);

`ifdef FIFO_ARB_BURST_EN
   localparam bit BURST_EN = (MAX_BURST > 1);
`else
   localparam bit BURST_EN = 1'b0;
`endif

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t           state, state_nxt;
   logic [ID_W-1:0]  rr_ptr, rr_ptr_nxt;
   logic [ID_W-1:0]  owner, owner_nxt;
   logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt, cnt_inc;
   logic [ID_W-1:0]  win, sel;
   logic             found, grant;
   int               idx;

   function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
      int n;
      n = int'(id) + 1;
      if (n >= NUM_REQ) n = 0;
      return n[ID_W-1:0];
   endfunction

   // First asserted request at or above rr_ptr, wrapping past NUM_REQ-1
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && bus.req[idx[ID_W-1:0]]) begin
            found = 1'b1;
            win   = idx[ID_W-1:0];
         end
      end
   end

   always_ff @(posedge wr_clk) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         owner     <= '0;
         burst_cnt <= '0;
      end else begin
         state     <= state_nxt;
         rr_ptr    <= rr_ptr_nxt;
         owner     <= owner_nxt;
         burst_cnt <= burst_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      rr_ptr_nxt    = rr_ptr;
      owner_nxt     = owner;
      burst_cnt_nxt = burst_cnt;
      grant         = 1'b0;
      sel           = '0;
      cnt_inc       = burst_cnt + CNT_W'(1);
      case (state)
         IDLE: begin
            if (found && !bus.full) begin
               grant         = 1'b1;
               sel           = win;
               burst_cnt_nxt = CNT_W'(1);
               if (BURST_EN && !bus.almost_full) begin
                  state_nxt = BURST;
                  owner_nxt = win;
               end else begin
                  rr_ptr_nxt = next_id(win);
               end
            end
         end
         BURST: begin
            if (!bus.req[owner]) begin
               state_nxt  = IDLE;
               rr_ptr_nxt = next_id(owner);
            end else if (!bus.full) begin
               grant         = 1'b1;
               sel           = owner;
               burst_cnt_nxt = cnt_inc;
               // Almost-full cuts the burst short after this word lands
               if (cnt_inc == CNT_W'(MAX_BURST) || bus.almost_full) begin
                  state_nxt  = IDLE;
                  rr_ptr_nxt = next_id(owner);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Write path is combinational so the word goes out in the grant cycle
   always_comb begin
      bus.ack     = '0;
      bus.wr_data = '0;
      if (grant && !rst) begin
         bus.ack[sel] = 1'b1;
         bus.wr_data  = bus.req_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign bus.wr_enbl = |bus.ack;

`ifdef FIFO_ARB_BURST_EN
   assign bus.owner_vld = (state == BURST) && !rst;
   assign bus.owner_id  = owner;
`else
   assign bus.owner_vld = 1'b0;
   assign bus.owner_id  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Purpose  : Directed self-checking bench for fifo_wr_arbiter (both builds of
//            FIFO_ARB_BURST_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_wr_arbiter;

`ifdef FIFO_ARB_BURST_EN
   localparam logic BE = 1'b1;
`else
   localparam logic BE = 1'b0;
`endif

   logic wr_clk;
   logic rst;
   int   n_chk;
   int   n_err;
   logic [7:0] words [4];

   fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

   fifo_wr_arbiter #(
      .NUM_REQ    (4),
      .DATA_WIDTH (8),
      .MAX_BURST  (4)
   ) dut (
      .wr_clk (wr_clk),
      .rst    (rst),
      .bus    (bus)
   );

   initial wr_clk = 1'b0;
   always #5 wr_clk = ~wr_clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge wr_clk);
      #1;
   endtask

   // Inputs are already applied; check this cycle's outputs, then advance
   task automatic cyc(input string tag, input logic [3:0] e_ack, input logic e_vld, input int e_id);
      logic [7:0] e_data;
      #1;
      e_data = 8'h00;
      for (int i = 0; i < 4; i++)
         if (e_ack[i]) e_data = words[i];
      check_val({tag, ".ack"},   32'(bus.ack),       32'(e_ack));
      check_val({tag, ".wen"},   32'(bus.wr_enbl),   32'(|e_ack));
      check_val({tag, ".wdata"}, 32'(bus.wr_data),   32'(e_data));
      check_val({tag, ".ovld"},  32'(bus.owner_vld), 32'(e_vld));
      if (e_vld) check_val({tag, ".oid"}, 32'(bus.owner_id), 32'(e_id));
      tick();
   endtask

   task automatic do_reset();
      rst             = 1'b1;
      bus.req         = 4'b0000;
      bus.full        = 1'b0;
      bus.almost_full = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      words = '{8'h11, 8'h22, 8'h33, 8'h44};
      bus.req_data    = {words[3], words[2], words[1], words[0]};
      rst             = 1'b1;
      bus.req         = 4'b0000;
      bus.full        = 1'b0;
      bus.almost_full = 1'b0;
      tick();
      tick();

      // Outputs held at zero while reset is asserted, even with requests
      bus.req = 4'b1111;
      cyc("rst_hold", 4'b0000, 1'b0, 0);

      // Single requester: burst of four, then a fresh IDLE grant
      do_reset();
      bus.req = 4'b0001;
      cyc("single0", 4'b0001, 1'b0, 0);
      cyc("single1", 4'b0001, BE, 0);
      cyc("single2", 4'b0001, BE, 0);
      cyc("single3", 4'b0001, BE, 0);
      cyc("single_regrant", 4'b0001, 1'b0, 0);
      bus.req = 4'b0000;
      cyc("single_drop", 4'b0000, BE, 0);
      cyc("single_idle", 4'b0000, 1'b0, 0);

      // Fairness with all requesters pending
      do_reset();
      bus.req = 4'b1111;
`ifdef FIFO_ARB_BURST_EN
      for (int r = 0; r < 4; r++)
         for (int b = 0; b < 4; b++)
            cyc("fair", 4'b0001 << r, (b != 0), r);
`else
      for (int r = 0; r < 5; r++)
         cyc("fair", 4'b0001 << (r % 4), 1'b0, 0);
`endif

      // Full stall with owner 2 after two writes
      do_reset();
      bus.req = 4'b0100;
      cyc("stall_w1", 4'b0100, 1'b0, 2);
      cyc("stall_w2", 4'b0100, BE, 2);
      bus.full = 1'b1;
      for (int s = 0; s < 5; s++)
         cyc("stall_full", 4'b0000, BE, 2);
      bus.full = 1'b0;
      cyc("stall_w3", 4'b0100, BE, 2);
      cyc("stall_w4", 4'b0100, BE, 2);
      cyc("stall_rel", 4'b0100, 1'b0, 2);

      // Almost full forces single-write grants
      do_reset();
      bus.almost_full = 1'b1;
      bus.req         = 4'b0011;
      cyc("af0", 4'b0001, 1'b0, 0);
      cyc("af1", 4'b0010, 1'b0, 0);
      cyc("af2", 4'b0001, 1'b0, 0);
      cyc("af3", 4'b0010, 1'b0, 0);

      // Early drop by owner 1; next scan starts at 2
      do_reset();
      bus.req = 4'b0010;
      cyc("drop_w", 4'b0010, 1'b0, 1);
      bus.req = 4'b0000;
      cyc("drop_rel", 4'b0000, BE, 1);
      cyc("drop_idle", 4'b0000, 1'b0, 0);
      bus.req = 4'b0111;
      cyc("drop_ptr", 4'b0100, 1'b0, 0);

      // Reset in the middle of owner 3's burst
      do_reset();
      bus.req = 4'b1000;
      cyc("mrst_w1", 4'b1000, 1'b0, 3);
      cyc("mrst_w2", 4'b1000, BE, 3);
      rst = 1'b1;
      cyc("mrst_hold", 4'b0000, 1'b0, 0);
      rst     = 1'b0;
      bus.req = 4'b1111;
      cyc("mrst_after", 4'b0001, 1'b0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
